inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Fetch stage directly upstream of the opcode decoder/control unit. Holds the PC and issues one request at a time to instruction memory over a valid/ready request and valid response interface. It presents the fetched instruction with inst_valid/inst_ready. When the instruction is consumed, it computes the next PC from the control/execute outcome (jal, jalr, taken branch) and halts on an ecall-halt request.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address (= pc)
imem_resp_valid  input  1  instruction data valid
imem_resp_data  input  32  returned instruction word
inst_valid  output  1  inst/pc valid to decode
inst_ready  input  1  decode/execute consumes instruction this cycle
inst  output  32  held instruction word
pc  output  XLEN  PC of held instruction
is_jal  input  1  consumed instr is JAL
is_jalr  input  1  consumed instr is JALR
branch_taken  input  1  consumed instr is a branch and condition true
imm  input  XLEN  sign-extended immediate of consumed instr
rs1_data  input  XLEN  rs1 value (JALR base)
halt_req  input  1  consumed instr is ecall with x17==10
halted  output  1  fetch permanently stopped

Behaviour:
- Reset (reset==0 at clk edge): state<=REQ, pc<=RESET_PC, inst<=0, halted<=0. Outputs during/after reset cycle: imem_req_valid=1, inst_valid=0. Reset mid-transaction discards any outstanding response.
- FSM states: REQ, WAIT, VALID, HALT.
- REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready, go to WAIT. Otherwise stay in REQ; addr held stable and valid never withdrawn.
- WAIT: imem_req_valid=0. On imem_resp_valid, inst<=imem_resp_data and go to VALID. Responses arrive no earlier than the cycle after acceptance. resp_valid in REQ/VALID/HALT is ignored.
- VALID: inst_valid=1, inst and pc stable. On inst_ready:
  - if halt_req: go to HALT;
  - else pc<=next_pc and go to REQ.
  - Without inst_ready, hold indefinitely.
- HALT: halted=1, no requests, inst_valid=0. Exit only by reset.
- next_pc priority:
  - is_jalr: (rs1_data+imm) & ~1;
  - else is_jal: pc+imm;
  - else branch_taken: pc+imm;
  - else pc+4.
  - All additions are modulo 2^XLEN (wrap, no flag).
- Simultaneous halt_req with jump/branch: halt wins and pc is not updated.
- Minimum latency: REQ accepted in cycle 0, response in cycle 1, inst_valid in cycle 2. Peak throughput is 1 instr / 3 cycles.
- halted is registered and asserts the cycle after the accepting edge.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_TRAP_EN.
- With the macro: output misaligned (1 bit, reset 0). If the computed next_pc[1:0]!=0 on an accepting edge, go to HALT with misaligned=1, halted=1, and keep pc at the faulting instruction.
- Without the macro: the port is absent and next_pc bits [1:0] are forwarded unchanged.

Decomposition:
- Shared package: FSM state encoding (2-bit), RESET_PC default, XLEN, and the existing opcode constants (JAL/JALR/BRANCH/ECALL) so decode and fetch agree.
- One sub-module: next_pc_gen, a combinational block with inputs pc/imm/rs1_data/flags and output next_pc.

Test Plan:
- Reset with RESET_PC=0, ready=1, 1-cycle memory -> addr 0 issued in cycle 0, inst_valid in cycle 2; after accept, next request at addr 4.
- Hold imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 with addr stable; WAIT entered only on the ready cycle.
- Consume with is_jalr=1, rs1_data=0x1003, imm=4 -> next imem_addr=0x1006. With is_jal=1, pc=0x100, imm=-8 -> 0xF8.
- branch_taken=1 and is_jal=1 both set, imm=0x20, pc=0x40 -> next addr 0x60. Plain instr at pc=0xFFFF_FFFC -> next addr 0x0 (wrap).
- halt_req=1 together with branch_taken=1 -> halted=1 next cycle, no further imem_req_valid, pc unchanged; resp_valid pulses ignored.
- Assert reset while in WAIT, then a stale response arrives -> response ignored and fetch restarts at RESET_PC. With the macro: jal to pc+2 -> misaligned=1, halted=1.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, reset PC, fetch FSM
// encoding and the opcode constants decode and fetch agree on.
package inst_fetch_unit_pkg;

  localparam int          IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;

endpackage

// File: rtl/inst_fetch_unit_next_pc_gen.sv
// Next-PC selection for the fetch stage (combinational).
// Ports: pc, imm, rs1_data, is_jal, is_jalr, branch_taken -> next_pc.
module inst_fetch_unit_next_pc_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] seq_pc;

  assign jalr_sum = rs1_data + imm;
  assign rel_sum  = pc + imm;
  assign seq_pc   = pc + XLEN'(4);

  // Flags may overlap; jalr outranks jal, which outranks branch.
  always_comb begin
    next_pc = seq_pc;
    if (is_jalr) begin
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_jal || branch_taken) begin
      next_pc = rel_sum;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: holds PC, one imem request in flight, hands the word
// to decode and picks the next PC when it is consumed.
// Ports: clk/reset (sync, active-low); imem_req_valid/ready, imem_addr;
// imem_resp_valid/data; inst_valid/ready, inst, pc; is_jal, is_jalr,
// branch_taken, imm, rs1_data, halt_req; halted.
// Option: INST_FETCH_MISALIGN_TRAP_EN adds the misaligned output.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            halt_req,
  output logic            halted
`ifdef INST_FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;

  inst_fetch_unit_next_pc_gen #(
    .XLEN(XLEN)
  ) u_next_pc_gen (
    .pc          (pc),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .branch_taken(branch_taken),
    .next_pc     (next_pc)
  );

  // Handshake outputs are pure state decodes of the state register.
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_VALID);
  assign imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      inst   <= '0;
      halted <= 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst  <= imem_resp_data;
            state <= S_VALID;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            // Halt outranks any redirect; pc stays on the ecall.
            if (halt_req) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            else if (next_pc[1:0] != 2'b00) begin
              state      <= S_HALT;
              halted     <= 1'b1;
              misaligned <= 1'b1;
            end
`endif
            else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule
